// File: rtl/icache_line_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_line_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRefill
  } icache_state_e;

  localparam int unsigned InstrWidth = 32;

endpackage

// File: rtl/icache_line_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
interface icache_line_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  import icache_line_pkg::*;

  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_valid;
  logic                  jump_wrong;
  logic                  flush_all;
  logic                  instr_if_valid;
  logic [InstrWidth-1:0] instr_if;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_valid;
  logic [InstrWidth-1:0] mem_data;

  modport slave (
    input  pc, pc_valid, jump_wrong, flush_all, mem_valid, mem_data,
    output instr_if_valid, instr_if, mem_req, mem_addr
  );

  modport master (
    output pc, pc_valid, jump_wrong, flush_all, mem_valid, mem_data,
    input  instr_if_valid, instr_if, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_line_refill_fsm.sv
// Line refill sequencer: walks a missed line word by word and flags the critical-word forward.
module icache_line_refill_fsm
  import icache_line_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned OffBits   = $clog2(LINE_WORDS),
  localparam int unsigned BaseBits  = ADDR_WIDTH - OffBits - 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rdy_i,
  input  logic                  miss_i,
  input  logic [BaseBits-1:0]   miss_base_i,
  input  logic [OffBits-1:0]    miss_off_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  pc_valid_i,
  input  logic                  jump_wrong_i,
  input  logic                  flush_all_i,
  input  logic                  mem_valid_i,
  output icache_state_e         state_o,
  output logic [OffBits-1:0]    cnt_o,
  output logic [BaseBits-1:0]   line_base_o,
  output logic                  fwd_o,
  output logic                  done_o,
  output logic                  commit_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o
);

  localparam logic [OffBits-1:0] LastCnt = OffBits'(LINE_WORDS - 1);

  icache_state_e         state_q, state_d;
  logic [OffBits-1:0]    cnt_q, cnt_d, cnt_nxt;
  logic [BaseBits-1:0]   line_base_q, line_base_d;
  logic [OffBits-1:0]    req_off_q, req_off_d;
  logic                  discard_q, discard_d;
  logic                  fwd_kill_q, fwd_kill_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_base_d = line_base_q;
    req_off_d   = req_off_q;
    discard_d   = discard_q;
    fwd_kill_d  = fwd_kill_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    cnt_nxt     = cnt_q + OffBits'(1);
    fwd_o       = 1'b0;
    done_o      = 1'b0;
    commit_o    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (miss_i) begin
          state_d     = StRefill;
          line_base_d = miss_base_i;
          req_off_d   = miss_off_i;
          cnt_d       = '0;
          discard_d   = 1'b0;
          fwd_kill_d  = jump_wrong_i;
          mem_req_d   = 1'b1;
          mem_addr_d  = {miss_base_i, {OffBits{1'b0}}, 2'b00};
        end
      end
      StRefill: begin
        if (jump_wrong_i) fwd_kill_d = 1'b1;
        if (flush_all_i)  discard_d  = 1'b1;
        if (mem_valid_i) begin
          // Forward only if fetch is still waiting on exactly the missed pc.
          fwd_o = (cnt_q == req_off_q) && pc_valid_i && !fwd_kill_q &&
                  (pc_i == {line_base_q, req_off_q, 2'b00});
          cnt_d = cnt_nxt;
          if (cnt_q == LastCnt) begin
            done_o     = 1'b1;
            commit_o   = !discard_q && !flush_all_i;
            state_d    = StIdle;
            discard_d  = 1'b0;
            fwd_kill_d = 1'b0;
            mem_req_d  = 1'b0;
          end else begin
            mem_addr_d = {line_base_q, cnt_nxt, 2'b00};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      line_base_q <= '0;
      req_off_q   <= '0;
      discard_q   <= 1'b0;
      fwd_kill_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else if (rdy_i) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_base_q <= line_base_d;
      req_off_q   <= req_off_d;
      discard_q   <= discard_d;
      fwd_kill_q  <= fwd_kill_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign state_o     = state_q;
  assign cnt_o       = cnt_q;
  assign line_base_o = line_base_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;

endmodule

// File: rtl/icache_line.sv
// Direct-mapped instruction cache: tag/data arrays, hit compare and fetch output register.
module icache_line
  import icache_line_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         rdy_i,
  icache_line_if.slave bus
);

  localparam int unsigned OffBits  = $clog2(LINE_WORDS);
  localparam int unsigned TagBits  = ADDR_WIDTH - INDEX_BITS - OffBits - 2;
  localparam int unsigned BaseBits = TagBits + INDEX_BITS;
  localparam int unsigned Lines    = 2 ** INDEX_BITS;

  logic [Lines-1:0]      valid_q, valid_d;
  logic [TagBits-1:0]    tag_q  [Lines];
  logic [InstrWidth-1:0] data_q [Lines][LINE_WORDS];
  logic                  instr_valid_q, instr_valid_d;
  logic [InstrWidth-1:0] instr_q, instr_d;

  logic [TagBits-1:0]    pc_tag;
  logic [INDEX_BITS-1:0] pc_idx;
  logic [OffBits-1:0]    pc_off;
  logic                  hit, miss;

  icache_state_e         state;
  logic [OffBits-1:0]    cnt;
  logic [BaseBits-1:0]   line_base;
  logic                  fwd, done, commit;

  assign pc_tag = bus.pc[ADDR_WIDTH-1 -: TagBits];
  assign pc_idx = bus.pc[INDEX_BITS+OffBits+1 : OffBits+2];
  assign pc_off = bus.pc[OffBits+1 : 2];

  assign hit  = (state == StIdle) && bus.pc_valid && valid_q[pc_idx] &&
                (tag_q[pc_idx] == pc_tag);
  assign miss = (state == StIdle) && bus.pc_valid && !hit;

  icache_line_refill_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .INDEX_BITS(INDEX_BITS),
    .LINE_WORDS(LINE_WORDS)
  ) u_refill (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rdy_i       (rdy_i),
    .miss_i      (miss),
    .miss_base_i (bus.pc[ADDR_WIDTH-1 : OffBits+2]),
    .miss_off_i  (pc_off),
    .pc_i        (bus.pc),
    .pc_valid_i  (bus.pc_valid),
    .jump_wrong_i(bus.jump_wrong),
    .flush_all_i (bus.flush_all),
    .mem_valid_i (bus.mem_valid),
    .state_o     (state),
    .cnt_o       (cnt),
    .line_base_o (line_base),
    .fwd_o       (fwd),
    .done_o      (done),
    .commit_o    (commit),
    .mem_req_o   (bus.mem_req),
    .mem_addr_o  (bus.mem_addr)
  );

  always_comb begin
    valid_d = valid_q;
    if (bus.flush_all) valid_d = '0;
    if (done && commit) valid_d[line_base[INDEX_BITS-1:0]] = 1'b1;

    // A redirect squashes both a hit and a forward in the same cycle.
    instr_valid_d = !bus.jump_wrong && ((hit && !bus.flush_all) || fwd);
    instr_d       = instr_q;
    if (instr_valid_d) instr_d = hit ? data_q[pc_idx][pc_off] : bus.mem_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
    end else if (rdy_i) begin
      valid_q       <= valid_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rdy_i && (state == StRefill) && bus.mem_valid) begin
      data_q[line_base[INDEX_BITS-1:0]][cnt] <= bus.mem_data;
    end
    if (rdy_i && done) begin
      tag_q[line_base[INDEX_BITS-1:0]] <= line_base[BaseBits-1 : INDEX_BITS];
    end
  end

  assign bus.instr_if_valid = instr_valid_q;
  assign bus.instr_if       = instr_q;

endmodule

// File: tb/tb_icache_line.sv
// Randomised self-checking bench for icache_line against a line-level reference model.
module tb_icache_line;
  import icache_line_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned IB = 6;
  localparam int unsigned LW = 4;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  icache_line_if #(.ADDR_WIDTH(AW)) bus ();

  icache_line #(
    .ADDR_WIDTH(AW),
    .INDEX_BITS(IB),
    .LINE_WORDS(LW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rdy_i(rdy),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: which tag each line holds; data is always backing memory.
  bit          ref_valid [64];
  logic [21:0] ref_tag   [64];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1;
    return h ^ {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.pc_valid   = 1'b0;
    bus.jump_wrong = 1'b0;
    bus.flush_all  = 1'b0;
    bus.mem_valid  = 1'b0;
    bus.mem_data   = '0;
  endtask

  // Request one pc and, on a predicted miss, serve the refill with random latency.
  // kill_at/flush_at/rdy_at: word index before which that event is injected (-1: none).
  task automatic do_access(input logic [31:0] a, input int kill_at, input int flush_at,
                           input int rdy_at);
    logic [5:0]  idx;
    logic [21:0] tag;
    int          off;
    logic [31:0] base, wa;
    bit          exp_hit, killed, discard, exp_iv;
    idx     = a[9:4];
    tag     = a[31:10];
    off     = int'(a[3:2]);
    base    = {a[31:4], 4'h0};
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);
    killed  = 1'b0;
    discard = 1'b0;
    exp_iv  = 1'b0;
    bus.pc       = a;
    bus.pc_valid = 1'b1;
    tick();
    checks++;
    if (exp_hit) begin
      if (bus.instr_if_valid !== 1'b1 || bus.instr_if !== mem_word(a)) begin
        errors++;
        $display("FAIL hit pc=%h: got valid=%b instr=%h, expected valid=1 instr=%h",
                 a, bus.instr_if_valid, bus.instr_if, mem_word(a));
      end
      checks++;
      if (bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL hit_no_req pc=%h: got mem_req=%b, expected 0", a, bus.mem_req);
      end
      bus.pc_valid = 1'b0;
      return;
    end
    if (bus.mem_req !== 1'b1 || bus.instr_if_valid !== 1'b0 || bus.mem_addr !== base) begin
      errors++;
      $display("FAIL miss_start pc=%h: got req=%b valid=%b addr=%h, expected 1 0 %h",
               a, bus.mem_req, bus.instr_if_valid, bus.mem_addr, base);
    end
    for (int w = 0; w < int'(LW); w++) begin
      wa = base + 32'(4 * w);
      if (w == kill_at) begin
        bus.jump_wrong = 1'b1;
        tick();
        bus.jump_wrong = 1'b0;
        killed = 1'b1;
        exp_iv = 1'b0;
        checks++;
        if (bus.instr_if_valid !== 1'b0) begin
          errors++;
          $display("FAIL kill_squash pc=%h: got valid=%b, expected 0", a, bus.instr_if_valid);
        end
      end
      if (w == flush_at) begin
        bus.flush_all = 1'b1;
        tick();
        bus.flush_all = 1'b0;
        discard = 1'b1;
        exp_iv  = 1'b0;
        clear_model();
      end
      repeat ($urandom_range(0, 2)) begin
        tick();
        exp_iv = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== wa || bus.instr_if_valid !== 1'b0) begin
          errors++;
          $display("FAIL refill_wait pc=%h w=%0d: got req=%b addr=%h valid=%b, expected 1 %h 0",
                   a, w, bus.mem_req, bus.mem_addr, bus.instr_if_valid, wa);
        end
      end
      if (w == rdy_at) begin
        rdy = 1'b0;
        repeat (3) begin
          bus.mem_valid = 1'b1;
          bus.mem_data  = $urandom;
          tick();
          checks++;
          if (bus.mem_req !== 1'b1 || bus.mem_addr !== wa || bus.instr_if_valid !== exp_iv ||
              (exp_iv && bus.instr_if !== mem_word(a))) begin
            errors++;
            $display("FAIL rdy_freeze pc=%h w=%0d: got req=%b addr=%h valid=%b, expected 1 %h %b",
                     a, w, bus.mem_req, bus.mem_addr, bus.instr_if_valid, wa, exp_iv);
          end
        end
        bus.mem_valid = 1'b0;
        rdy = 1'b1;
      end
      bus.mem_valid = 1'b1;
      bus.mem_data  = mem_word(wa);
      tick();
      bus.mem_valid = 1'b0;
      exp_iv = (w == off) && !killed;
      checks++;
      if (bus.instr_if_valid !== exp_iv || (exp_iv && bus.instr_if !== mem_word(a))) begin
        errors++;
        $display("FAIL forward pc=%h w=%0d: got valid=%b instr=%h, expected valid=%b instr=%h",
                 a, w, bus.instr_if_valid, bus.instr_if, exp_iv, mem_word(a));
      end
      checks++;
      if (w < int'(LW) - 1) begin
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== wa + 32'd4) begin
          errors++;
          $display("FAIL next_addr pc=%h w=%0d: got req=%b addr=%h, expected 1 %h",
                   a, w, bus.mem_req, bus.mem_addr, wa + 32'd4);
        end
      end else if (bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL req_drop pc=%h: got mem_req=%b, expected 0", a, bus.mem_req);
      end
    end
    bus.pc_valid = 1'b0;
    if (!discard) begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tag;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.instr_if_valid !== 1'b0 || bus.instr_if !== 32'h0 || bus.mem_req !== 1'b0 ||
        bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b instr=%h req=%b addr=%h, expected all 0",
               bus.instr_if_valid, bus.instr_if, bus.mem_req, bus.mem_addr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss_and_hits();
    do_access(32'h0000_1008, -1, -1, -1);
    do_access(32'h0000_1000, -1, -1, -1);
    do_access(32'h0000_100C, -1, -1, -1);
    do_access(32'h0000_3FFC, -1, -1, -1);
    do_access(32'h0000_3FF0, -1, -1, -1);
  endtask

  task automatic test_conflict();
    do_access(32'h0000_1400, -1, -1, -1);
    do_access(32'h0000_1000, -1, -1, -1);
  endtask

  task automatic test_jump_wrong();
    do_access(32'h0000_1028, 1, -1, -1);
    do_access(32'h0000_1028, -1, -1, -1);
    // Squash beats a hit; the next lookup proceeds as jump_wrong falls.
    bus.pc         = 32'h0000_1020;
    bus.pc_valid   = 1'b1;
    bus.jump_wrong = 1'b1;
    tick();
    checks++;
    if (bus.instr_if_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL jump_hit_squash: got valid=%b req=%b, expected 0 0",
               bus.instr_if_valid, bus.mem_req);
    end
    bus.jump_wrong = 1'b0;
    tick();
    checks++;
    if (bus.instr_if_valid !== 1'b1 || bus.instr_if !== mem_word(32'h0000_1020)) begin
      errors++;
      $display("FAIL jump_then_hit: got valid=%b instr=%h, expected 1 %h",
               bus.instr_if_valid, bus.instr_if, mem_word(32'h0000_1020));
    end
    bus.pc_valid = 1'b0;
  endtask

  task automatic test_flush();
    do_access(32'h0000_1048, -1, 2, -1);
    do_access(32'h0000_1048, -1, -1, -1);
    do_access(32'h0000_1000, -1, -1, -1);
    do_access(32'h0000_1004, -1, -1, -1);
    bus.flush_all = 1'b1;
    tick();
    bus.flush_all = 1'b0;
    clear_model();
    checks++;
    if (bus.instr_if_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_flush: got valid=%b req=%b, expected 0 0",
               bus.instr_if_valid, bus.mem_req);
    end
    do_access(32'h0000_1004, -1, -1, -1);
    do_access(32'h0000_1048, -1, -1, -1);
  endtask

  task automatic test_rdy();
    do_access(32'h0000_1084, -1, -1, 1);
    do_access(32'h0000_10C4, -1, -1, 2);
    do_access(32'h0000_1084, -1, -1, -1);
  endtask

  task automatic test_async_reset();
    bus.pc       = 32'h0000_2018;
    bus.pc_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b1;
    bus.mem_data  = mem_word(32'h0000_2010);
    tick();
    bus.mem_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.instr_if_valid !== 1'b0 || bus.instr_if !== 32'h0 || bus.mem_req !== 1'b0 ||
        bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b instr=%h req=%b addr=%h, expected all 0",
               bus.instr_if_valid, bus.instr_if, bus.mem_req, bus.mem_addr);
    end
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    clear_model();
    tick();
    do_access(32'h0000_1084, -1, -1, -1);
    do_access(32'h0000_1000, -1, -1, -1);
    do_access(32'h0000_2018, -1, -1, -1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          k, f, r;
    for (int n = 0; n < 60; n++) begin
      a = 32'h0001_0000 + 32'($urandom_range(0, 3) << 10) + 32'($urandom_range(0, 3) << 4) +
          32'($urandom_range(0, 3) << 2);
      k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      f = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      r = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_access(a, k, f, r);
      if ($urandom_range(0, 11) == 0) begin
        bus.flush_all = 1'b1;
        tick();
        bus.flush_all = 1'b0;
        clear_model();
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.pc = '0;
    idle_inputs();
    clear_model();
    #12;
    test_reset();
    test_cold_miss_and_hits();
    test_conflict();
    test_jump_wrong();
    test_flush();
    test_rdy();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_line.md
Name: icache_line

Overview:
- Parametrised direct-mapped instruction cache with multi-word lines.
- Sits between InstructionFetch and the memory controller. Serves one instruction per cycle on a hit; on a miss, refills a whole line word-by-word through the memory controller port.
- Forwards the critical word to fetch as soon as it arrives.
- Supports redirect squash (jump_wrong) and full invalidation (flush_all, for fence.i).

Parameters:
- ADDR_WIDTH, 32, byte-address width of pc and mem_addr.
- INDEX_BITS, 6, log2 of line count (64 lines).
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2.
- Derived (localparam, not overridable):
  - OFF_BITS = log2(LINE_WORDS).
  - TAG_BITS = ADDR_WIDTH-INDEX_BITS-OFF_BITS-2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; low freezes all state
- pc  in  ADDR_WIDTH  fetch address (word aligned)
- pc_valid  in  1  fetch requests an instruction at pc this cycle
- jump_wrong  in  1  mispredict redirect; squash the in-flight response
- flush_all  in  1  invalidate every line
- instr_IF_valid  out  1  instr_IF holds the instruction for the pc requested
- instr_IF  out  32  instruction word
- mem_req  out  1  word fetch request to the memory controller
- mem_addr  out  ADDR_WIDTH  word address being fetched
- mem_valid  in  1  one-cycle pulse; mem_data belongs to the current mem_addr
- mem_data  in  32  returned word

Behaviour:
- Address split: offset = pc[OFF_BITS+1:2], index = pc[INDEX_BITS+OFF_BITS+1:OFF_BITS+2], tag = the upper bits.
- Storage:
  - valid[2^INDEX_BITS] is a flop vector with async reset.
  - tag and data arrays are not reset.
- Reset (async): state=IDLE, valid=0, instr_IF_valid=0, instr_IF=0, mem_req=0, mem_addr=0, counters=0, discard=0.
- rdy=0: no state change and no output change; mem_valid is ignored.
- State IDLE:
  - pc_valid && hit: next cycle instr_IF_valid=1 and instr_IF=data[index][offset] (1-cycle latency).
  - pc_valid && miss: latch line base {tag,index} and req_off=offset; cnt=0; go REFILL; instr_IF_valid=0.
  - !pc_valid: instr_IF_valid=0.
- State REFILL:
  - mem_req=1 and mem_addr={line_base, cnt, 2'b00}; words are fetched in order 0..LINE_WORDS-1.
  - On mem_valid: write data[index][cnt]=mem_data and increment cnt.
  - Critical-word forward: if cnt==req_off, pc_valid, pc equals the latched pc, and fwd_kill=0, then next cycle instr_IF_valid=1 and instr_IF=mem_data.
  - On mem_valid with cnt==LINE_WORDS-1: write tag; set valid[index]=!discard; clear discard and fwd_kill; go IDLE; mem_req drops the next cycle.
  - While in REFILL, instr_IF_valid=0 except for the forward cycle.
- jump_wrong (any state): instr_IF_valid<=0 next cycle.
  - In REFILL the refill runs to completion, because the line data is still correct.
  - Set fwd_kill so a later critical word is not forwarded.
- flush_all:
  - In IDLE: clear all valid bits next cycle; instr_IF_valid<=0.
  - In REFILL: clear valid and set discard, so the line in progress completes but is not validated.
- Simultaneous events:
  - flush_all with a completing refill: discard wins; the line stays invalid.
  - jump_wrong with a hit request: squash takes priority, so instr_IF_valid=0.
- In IDLE a new pc after a redirect is looked up normally in the same cycle jump_wrong falls.
- At most one outstanding refill; there is no hit-under-miss.
- Index wrap: line base is tag|index; cnt wraps within the line only and never carries into the index.

Decomposition:
- Shared defines (defines.v): ICACHE state encodings (IDLE, REFILL) and the instruction width constant 32.
- One sub-module is natural: icache_refill_fsm. It owns state, cnt, line_base, req_off, discard, fwd_kill, mem_req and mem_addr.
- The top module holds the arrays, hit compare and output register.

Test Plan (defaults: LINE_WORDS=4, INDEX_BITS=6):
- Cold miss at pc=0x1008 (index 0, offset 2):
  - mem_addr sequence is 0x1000, 0x1004, 0x1008, 0x100C.
  - instr_IF_valid is asserted once, with the 0x1008 word, the cycle after its mem_valid.
  - mem_req drops after the 4th word.
- Hit after fill: pc=0x1000 then 0x100C → instr_IF_valid=1 one cycle after each request, with the stored words; mem_req stays 0.
- Conflict: fill 0x1000, then request 0x1400 (same index, different tag).
  - Expect a refill from 0x1400 through 0x140C.
  - A re-request of 0x1000 then misses again.
- jump_wrong pulsed during a refill before the critical word arrives:
  - No forward occurs, and instr_IF_valid stays 0.
  - The line still completes; a later request to 0x1008 hits with 1-cycle latency.
- flush_all mid-refill, and separately in IDLE:
  - A subsequent request to any previously filled pc misses (mem_req=1).
  - In the mid-refill case, the line that was filling is also invalid.
- Async reset asserted mid-REFILL (not on a clock edge):
  - Outputs go to 0 immediately; state returns to IDLE.
  - After release, every request misses.
- rdy held low for 3 cycles with mem_valid pulsing: cnt and the outputs are unchanged; behaviour resumes normally when rdy returns.
